// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the ALU command sequencer
package alu_pkg;

    localparam int ANCHO_DATO = 8;
    localparam int ANCHO_OP   = 3;
    localparam int ANCHO_CANT = 5;

    // Bit positions of the flags inside the flag byte and the banderas vector
    localparam int BIT_C = 3;
    localparam int BIT_V = 2;
    localparam int BIT_N = 1;
    localparam int BIT_Z = 0;

    typedef enum logic [2:0] {
        CARGA_A  = 3'd0,
        CARGA_B  = 3'd1,
        CARGA_OP = 3'd2,
        EJEC     = 3'd3,
        ENV_RES  = 3'd4,
        ENV_FLG  = 3'd5
    } estado_t;

endpackage

// File: rtl/alu_secuenciador.sv
// rtl/alu_secuenciador.sv - byte-serial command front end for the flag-producing ALU
module alu_secuenciador
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] dato_in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] dato_out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] a_o,
    output logic [7:0] b_o,
    output logic [2:0] alu_control_o,
    output logic [4:0] cantidad_o,
    input  logic [7:0] resultado_i,
    input  logic       carry_i,
    input  logic       overflow_i,
    input  logic       negative_i,
    input  logic       zero_i,
    output logic [3:0] banderas,
    output logic       ocupado
);

    estado_t                 estado_q, estado_d;
    logic [ANCHO_DATO-1:0]   a_q, b_q, res_q;
    logic [ANCHO_OP-1:0]     op_q;
    logic [ANCHO_CANT-1:0]   cant_q;
    logic [3:0]              flags_q;
    logic [3:0]              flags_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    // Flags from the ALU packed into {C,V,N,Z} order
    always_comb begin
        flags_d        = '0;
        flags_d[BIT_C] = carry_i;
        flags_d[BIT_V] = overflow_i;
        flags_d[BIT_N] = negative_i;
        flags_d[BIT_Z] = zero_i;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= CARGA_A;
        end else begin
            estado_q <= estado_d;
        end
    end

    // Next state: loads advance on input transfers, responses on output transfers
    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            CARGA_A:  if (in_xfer)  estado_d = CARGA_B;
            CARGA_B:  if (in_xfer)  estado_d = CARGA_OP;
            CARGA_OP: if (in_xfer)  estado_d = EJEC;
            EJEC:                   estado_d = ENV_RES;
            ENV_RES:  if (out_xfer) estado_d = ENV_FLG;
            ENV_FLG:  if (out_xfer) estado_d = CARGA_A;
            default:                estado_d = CARGA_A;
        endcase
    end

    // Handshake and response outputs decoded from the state
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        dato_out  = '0;
        ocupado   = (estado_q != CARGA_A);
        case (estado_q)
            CARGA_A, CARGA_B, CARGA_OP: in_ready = 1'b1;
            ENV_RES: begin
                out_valid = 1'b1;
                dato_out  = res_q;
            end
            ENV_FLG: begin
                out_valid = 1'b1;
                dato_out  = {4'b0000, flags_q};
            end
            default: ;
        endcase
    end

    // Operand/opcode loads on transfers; result and flags only at the EJEC edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cant_q  <= '0;
            res_q   <= '0;
            flags_q <= '0;
        end else begin
            if (in_xfer) begin
                case (estado_q)
                    CARGA_A:  a_q <= dato_in;
                    CARGA_B:  b_q <= dato_in;
                    CARGA_OP: begin
                        op_q   <= dato_in[7:5];
                        cant_q <= dato_in[4:0];
                    end
                    default: ;
                endcase
            end
            if (estado_q == EJEC) begin
                res_q   <= resultado_i;
                flags_q <= flags_d;
            end
        end
    end

    assign a_o           = a_q;
    assign b_o           = b_q;
    assign alu_control_o = op_q;
    assign cantidad_o    = cant_q;
    assign banderas      = flags_q;

endmodule

// File: tb/tb_alu_secuenciador.sv
// tb/tb_alu_secuenciador.sv - scoreboard bench for alu_secuenciador with a behavioural ALU
module tb_alu_secuenciador;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] dato_in = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dato_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] a_o, b_o;
    logic [2:0] alu_control_o;
    logic [4:0] cantidad_o;
    logic [7:0] resultado_i;
    logic       carry_i, overflow_i, negative_i, zero_i;
    logic [3:0] banderas;
    logic       ocupado;

    alu_secuenciador dut (
        .clk(clk), .rst_n(rst_n), .dato_in(dato_in), .in_valid(in_valid), .in_ready(in_ready),
        .dato_out(dato_out), .out_valid(out_valid), .out_ready(out_ready),
        .a_o(a_o), .b_o(b_o), .alu_control_o(alu_control_o), .cantidad_o(cantidad_o),
        .resultado_i(resultado_i), .carry_i(carry_i), .overflow_i(overflow_i),
        .negative_i(negative_i), .zero_i(zero_i), .banderas(banderas), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] d;
        logic       es_flg;
    } esperado_t;

    esperado_t exp_q[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int rst_cnt = 0;
    int or_mode = 0;   // 0: always ready, 1: random, 2: held low

    // Behavioural ALU: returns {result, C, V, N, Z}
    function automatic logic [11:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [2:0] op, input logic [4:0] sh);
        int ai, bi, r;
        logic c, v;
        logic [7:0] res;
        ai = int'(a); bi = int'(b); c = 1'b0; v = 1'b0; r = 0;
        case (op)
            3'd0: begin r = ai + bi; c = (r > 255); end
            3'd1: begin r = ai - bi; c = (ai >= bi); end
            3'd2: r = ai & bi;
            3'd3: r = ai | bi;
            3'd4: r = ai ^ bi;
            3'd5: r = (sh >= 5'd8) ? 0 : ((ai << sh) & 255);
            3'd6: r = (sh >= 5'd8) ? 0 : (ai >> sh);
            default: r = ai;
        endcase
        res = r[7:0];
        if (op == 3'd0) v = (a[7] == b[7]) && (res[7] != a[7]);
        if (op == 3'd1) v = (a[7] != b[7]) && (res[7] != a[7]);
        return {res, c, v, res[7], (res == 8'h00)};
    endfunction

    always_comb {resultado_i, carry_i, overflow_i, negative_i, zero_i} =
        alu_ref(a_o, b_o, alu_control_o, cantidad_o);

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge rst_n) rst_cnt = rst_cnt + 1;

    always @(posedge clk) begin
        #2;
        case (or_mode)
            0: out_ready = 1'b1;
            2: out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    task automatic chk(input string nombre, input logic [7:0] act, input logic [7:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", nombre, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on each accepted response byte and checks hold behaviour
    logic       pv = 1'b0;
    logic       p_acc = 1'b0;
    logic [7:0] pd = 8'h00;
    int         p_rst = 0;
    always @(negedge clk) begin
        esperado_t e;
        if (rst_n) begin
            if (pv && !p_acc && p_rst == rst_cnt) begin
                chk("hold_valid", {7'd0, out_valid}, 8'h01);
                chk("hold_dato", dato_out, pd);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_resp: got 0x%02h expected none", dato_out);
                end else begin
                    e = exp_q.pop_front();
                    chk(e.es_flg ? "flag_byte" : "result_byte", dato_out, e.d);
                    if (e.es_flg) chk("banderas", {4'd0, banderas}, e.d);
                end
            end
            pv = out_valid; pd = dato_out; p_acc = out_valid && out_ready; p_rst = rst_cnt;
        end else begin
            pv = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] v, input int gap, output int t);
        int n;
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
        dato_in = v; in_valid = 1'b1; n = 0;
        while (!in_ready && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        t = cyc;
        in_valid = 1'b0; dato_in = 8'($urandom);
        @(negedge clk);
    endtask

    task automatic cmd(input logic [7:0] a, input logic [7:0] b, input logic [7:0] o,
                       input int gap, output int t0);
        logic [11:0] r;
        int t;
        r = alu_ref(a, b, o[7:5], o[4:0]);
        exp_q.push_back('{d: r[11:4], es_flg: 1'b0});
        exp_q.push_back('{d: {4'b0000, r[3:0]}, es_flg: 1'b1});
        send_byte(a, gap, t0);
        send_byte(b, gap, t);
        send_byte(o, gap, t);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((ocupado || exp_q.size() != 0) && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) begin
            n_cmp++; n_err++;
            $display("FAIL idle_timeout: got busy expected idle");
        end
    endtask

    task automatic wait_out_valid();
        int n = 0;
        while (!out_valid && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL out_valid_timeout: got 0 expected 1");
        end
    endtask

    initial begin
        int t0, t;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", {7'd0, in_ready}, 8'h01);
        chk("rst_out_valid", {7'd0, out_valid}, 8'h00);
        chk("rst_ocupado", {7'd0, ocupado}, 8'h00);
        chk("rst_dato_out", dato_out, 8'h00);
        chk("rst_banderas", {4'd0, banderas}, 8'h00);
        chk("rst_a", a_o, 8'h00);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic command: 0x7F + 0x01
        cmd(8'h7F, 8'h01, 8'h00, 0, t0);
        wait_idle();
        chk("cmd_period", 8'(cyc - t0 + 1), 8'd6);
        chk("basic_a", a_o, 8'h7F);
        chk("basic_b", b_o, 8'h01);
        chk("basic_banderas", {4'd0, banderas}, 8'h06);

        // Input gaps: state must not move while in_valid is low
        exp_q.push_back('{d: 8'h80, es_flg: 1'b0});
        exp_q.push_back('{d: 8'h06, es_flg: 1'b1});
        send_byte(8'h7F, 3, t);
        repeat (3) begin
            chk("gap_in_ready", {7'd0, in_ready}, 8'h01);
            chk("gap_out_valid", {7'd0, out_valid}, 8'h00);
            @(negedge clk);
        end
        send_byte(8'h01, 0, t);
        repeat (3) begin
            chk("gap2_in_ready", {7'd0, in_ready}, 8'h01);
            @(negedge clk);
        end
        send_byte(8'h00, 0, t);
        wait_idle();
        chk("gap_banderas", {4'd0, banderas}, 8'h06);

        // Output back-pressure in ENV_RES
        or_mode = 2;
        repeat (2) @(negedge clk);
        cmd(8'h7F, 8'h01, 8'h00, 0, t);
        wait_out_valid();
        repeat (5) begin
            chk("bp_dato", dato_out, 8'h80);
            chk("bp_valid", {7'd0, out_valid}, 8'h01);
            chk("bp_in_ready", {7'd0, in_ready}, 8'h00);
            @(negedge clk);
        end
        or_mode = 0;
        wait_idle();

        // Opcode split: 0xA7 -> op 5, shift 7
        cmd(8'h03, 8'h55, 8'hA7, 0, t);
        wait_idle();
        repeat (2) @(negedge clk);
        chk("op_split", {5'd0, alu_control_o}, 8'h05);
        chk("cant_split", {3'd0, cantidad_o}, 8'h07);
        chk("op_hold_a", a_o, 8'h03);

        // Reset in ENV_FLG: accept the result byte, then stall on the flag byte
        or_mode = 2;
        repeat (2) @(negedge clk);
        cmd(8'h7F, 8'h01, 8'h00, 0, t);
        wait_out_valid();
        or_mode = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        or_mode = 2;
        @(negedge clk);
        chk("flg_pending_valid", {7'd0, out_valid}, 8'h01);
        chk("flg_pending_dato", dato_out, 8'h06);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {7'd0, out_valid}, 8'h00);
        chk("midrst_banderas", {4'd0, banderas}, 8'h00);
        chk("midrst_ocupado", {7'd0, ocupado}, 8'h00);
        exp_q.delete();
        @(posedge clk); #3 rst_n = 1'b1;
        or_mode = 0;
        @(negedge clk);
        cmd(8'h00, 8'h00, 8'h00, 0, t);
        wait_idle();
        chk("zero_banderas", {4'd0, banderas}, 8'h01);

        // Randomized commands with random gaps and back-pressure
        or_mode = 1;
        for (int i = 0; i < 25; i++) begin
            cmd(8'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), t);
        end
        wait_idle();
        chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
